// File: rtl/expr_pipe_hs.sv
// expr_pipe_hs
//   Four-stage pipelined evaluator of q = ((a - b) * (1 + 3c) - 4d) >>> 1.
//   Intermediate values are kept at full precision. The result is then
//   either saturated or wrapped to OUT_WIDTH bits.
//   A single global enable (en = !q_valid || q_ready) advances every stage
//   at once. This gives full throughput with backpressure. Bubbles are
//   carried through the pipeline, not squeezed out.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   in_valid/ready   operand handshake; a, b, c, d, round_en travel with it
//   q_valid/ready    result handshake; q, q_ovf qualified by q_valid
//   ovf_cnt          saturating count of delivered overflowed results
//   cnt_clr          synchronous clear of ovf_cnt (beats a same-cycle bump)
module expr_pipe_hs #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SAT_EN    = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic                 round_en,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic [OUT_WIDTH-1:0] q,
  output logic                 q_ovf,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  input  logic                 cnt_clr
);

  localparam int PW = 2*WIDTH + 4;
  // The +1 for round half-up can never carry out of RW bits.
  localparam int RW = 2*WIDTH + 6;
  // The extended width must be wider than OUT_WIDTH.
  // Otherwise the overflow compare below would degenerate.
  localparam int EW = (RW > OUT_WIDTH) ? RW : OUT_WIDTH + 1;

  logic                 r_v1, r_v2, r_v3, r_v4;
  logic [WIDTH-1:0]     r_a1, r_b1, r_c1, r_d1;
  logic                 r_rnd1, r_rnd2, r_rnd3;
  logic [WIDTH:0]       r_diff2;
  logic [WIDTH+2:0]     r_k2, r_d4_2, r_d4_3;
  logic [PW-1:0]        r_p3;
  logic [OUT_WIDTH-1:0] r_q;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                        w_en;
  logic [WIDTH:0]              w_diff;
  logic [WIDTH+2:0]            w_c_x, w_k, w_d4;
  logic [PW-1:0]               w_diff_x, w_k_x, w_p;
  logic signed [RW-1:0]        w_r, w_s;
  logic signed [EW-1:0]        w_s_x;
  logic signed [OUT_WIDTH-1:0] w_s_lo;
  logic                        w_ovf;
  logic [OUT_WIDTH-1:0]        w_q;

  assign w_en     = !r_v4 || q_ready;
  assign in_ready = w_en && !rst;

  // Stage 2 arithmetic. Sign extension is explicit, so all operations
  // below are plain bit-vector math at the final width.
  assign w_diff = {r_a1[WIDTH-1], r_a1} - {r_b1[WIDTH-1], r_b1};
  assign w_c_x  = {{3{r_c1[WIDTH-1]}}, r_c1};
  assign w_k    = (w_c_x << 1) + w_c_x + (WIDTH+3)'(1);
  assign w_d4   = {r_d1[WIDTH-1], r_d1, 2'b00};

  // Stage 3: both factors are sign-extended to the product width.
  // The low PW bits of the unsigned product are then the exact signed product.
  assign w_diff_x = {{(WIDTH+3){r_diff2[WIDTH]}}, r_diff2};
  assign w_k_x    = {{(WIDTH+1){r_k2[WIDTH+2]}}, r_k2};
  assign w_p      = w_diff_x * w_k_x;

  // Stage 4: subtract, optional +1, then arithmetic shift.
  assign w_r = {{2{r_p3[PW-1]}}, r_p3}
             - {{(WIDTH+3){r_d4_3[WIDTH+2]}}, r_d4_3}
             + {{(RW-1){1'b0}}, r_rnd3};
  assign w_s = w_r >>> 1;

  // Overflow check: s overflows when it differs from its own low
  // OUT_WIDTH bits sign-extended back to full width.
  assign w_s_x  = EW'(w_s);
  assign w_s_lo = w_s_x[OUT_WIDTH-1:0];
  assign w_ovf  = (w_s_x != EW'(w_s_lo));

  always_comb begin
    w_q = w_s_x[OUT_WIDTH-1:0];
    if ((SAT_EN != 0) && w_ovf) begin
      w_q = w_s_x[EW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  // Valid bits and the output register are reset.
  // Everything else is don't-care while its valid bit is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_v4  <= 1'b0;
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_v1  <= in_valid;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_v4  <= r_v3;
      r_q   <= w_q;
      r_ovf <= w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_a1    <= a;
      r_b1    <= b;
      r_c1    <= c;
      r_d1    <= d;
      r_rnd1  <= round_en;
      r_diff2 <= w_diff;
      r_k2    <= w_k;
      r_d4_2  <= w_d4;
      r_rnd2  <= r_rnd1;
      r_p3    <= w_p;
      r_d4_3  <= r_d4_2;
      r_rnd3  <= r_rnd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else if (r_v4 && q_ready && r_ovf && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign q_valid = r_v4;
  assign q       = r_q;
  assign q_ovf   = r_ovf;
  assign ovf_cnt = r_cnt;

endmodule

// File: tb/tb_expr_pipe_hs.sv
// Bench for expr_pipe_hs. Three instances share the same stimulus:
//   u_sat8   8-bit in, 8-bit out, saturating, 2-bit counter
//   u_wrap8  8-bit in, 8-bit out, wrapping,   2-bit counter
//   u_sat16  8-bit in, 16-bit out, saturating, 4-bit counter
// The expected results come from integer arithmetic on each accepted beat.
// They are kept in a queue and checked in order.
module tb_expr_pipe_hs;
  logic clk = 1'b0;
  logic rst, in_valid, round_en, q_ready, cnt_clr;
  logic [7:0] a, b, c, d;
  logic ir0, ir1, ir2, qv0, qv1, qv2, ov0, ov1, ov2;
  logic [7:0] q0, q1;
  logic [15:0] q2;
  logic [1:0] cnt0, cnt1;
  logic [3:0] cnt2;

  always #5 clk = ~clk;

  expr_pipe_hs #(.WIDTH(8), .OUT_WIDTH(8), .SAT_EN(1), .CNT_WIDTH(2)) u_sat8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .c(c), .d(d),
    .round_en(round_en), .q_valid(qv0), .q_ready(q_ready), .q(q0), .q_ovf(ov0),
    .ovf_cnt(cnt0), .cnt_clr(cnt_clr));
  expr_pipe_hs #(.WIDTH(8), .OUT_WIDTH(8), .SAT_EN(0), .CNT_WIDTH(2)) u_wrap8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .c(c), .d(d),
    .round_en(round_en), .q_valid(qv1), .q_ready(q_ready), .q(q1), .q_ovf(ov1),
    .ovf_cnt(cnt1), .cnt_clr(cnt_clr));
  expr_pipe_hs #(.WIDTH(8), .OUT_WIDTH(16), .SAT_EN(1), .CNT_WIDTH(4)) u_sat16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b), .c(c), .d(d),
    .round_en(round_en), .q_valid(qv2), .q_ready(q_ready), .q(q2), .q_ovf(ov2),
    .ovf_cnt(cnt2), .cnt_clr(cnt_clr));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic at the specification level.
  function automatic int model_s(input int av, input int bv, input int cv, input int dv,
                                 input bit rv);
    return ((av - bv) * (1 + 3 * cv) - 4 * dv + int'(rv)) >>> 1;
  endfunction

  function automatic bit model_ovf(input int s, input int ow);
    return (s > (1 << (ow - 1)) - 1) || (s < -(1 << (ow - 1)));
  endfunction

  function automatic int model_q(input int s, input int ow, input bit sat);
    int v;
    v = s;
    if (sat && model_ovf(s, ow)) v = (s < 0) ? -(1 << (ow - 1)) : (1 << (ow - 1)) - 1;
    return v & ((1 << ow) - 1);
  endfunction

  // Monitor: scoreboard, counter model, handshake rules, output hold.
  int exp_q[$];
  int m_cnt0 = 0, m_cnt1 = 0, m_cnt2 = 0;
  int m_s;
  bit mon_on = 0, acc = 0, prev_stall = 0;
  logic [7:0] pq0;
  logic [15:0] pq2;
  logic pov0;
  int cyc = 0, acc_cyc = 0, n_hs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("cnt_sat8", cnt0, m_cnt0);
      chk("cnt_wrap8", cnt1, m_cnt1);
      chk("cnt_sat16", cnt2, m_cnt2);
      chk("qv_wrap8", qv1, qv0);
      chk("qv_sat16", qv2, qv0);
      if (rst) begin
        chk("in_ready_rst", ir0, 0);
        exp_q.delete();
        m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0;
        prev_stall = 0;
        acc = 0;
      end else begin
        chk("in_ready", ir0, (!qv0 || q_ready));
        if (prev_stall) begin
          chk("hold_valid", qv0, 1);
          chk("hold_q8", q0, pq0);
          chk("hold_q16", q2, pq2);
          chk("hold_ovf", ov0, pov0);
        end
        if (qv0) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", qv0, 0);
          end else begin
            m_s = exp_q[0];
            chk("q_sat8", q0, model_q(m_s, 8, 1));
            chk("ovf_sat8", ov0, model_ovf(m_s, 8));
            chk("q_wrap8", q1, model_q(m_s, 8, 0));
            chk("ovf_wrap8", ov1, model_ovf(m_s, 8));
            chk("q_sat16", q2, model_q(m_s, 16, 1));
            chk("ovf_sat16", ov2, model_ovf(m_s, 16));
            if (q_ready) begin
              void'(exp_q.pop_front());
              n_hs++;
              if (model_ovf(m_s, 8)) begin
                if (m_cnt0 < 3) m_cnt0++;
                if (m_cnt1 < 3) m_cnt1++;
              end
              if (model_ovf(m_s, 16) && m_cnt2 < 15) m_cnt2++;
            end
          end
        end
        if (cnt_clr) begin
          m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0;
        end
        acc = in_valid && ir0;
        if (acc) begin
          exp_q.push_back(model_s($signed(a), $signed(b), $signed(c), $signed(d), round_en));
          acc_cyc = cyc;
        end
        prev_stall = qv0 && !q_ready;
        pq0 = q0;
        pq2 = q2;
        pov0 = ov0;
      end
    end
  end

  // Directed-test helpers.
  logic [7:0] r_q0, r_q1;
  logic [15:0] r_q2;
  logic r_ov0, r_ov1, r_ov2;
  int r_cyc;

  task automatic send(input int av, input int bv, input int cv, input int dv, input bit rv);
    int g;
    bit ok;
    a = 8'(av); b = 8'(bv); c = 8'(cv); d = 8'(dv);
    round_en = rv;
    in_valid = 1'b1;
    g = 0; ok = 0;
    while (!ok && g < 200) begin
      @(negedge clk);
      ok = ir0 && !rst;
      g++;
    end
    if (!ok) chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int g;
    bit ok;
    g = 0; ok = 0;
    while (!ok && g < 200) begin
      @(negedge clk);
      ok = qv0 && q_ready;
      g++;
    end
    if (!ok) chk("result_timeout", ok, 1);
    r_q0 = q0; r_q1 = q1; r_q2 = q2;
    r_ov0 = ov0; r_ov1 = ov1; r_ov2 = ov2;
    r_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!qv0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!qv0) chk("valid_timeout", qv0, 1);
  endtask

  task automatic drain();
    int g;
    q_ready = 1'b1;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    g = 0;
    while ((exp_q.size() != 0 || qv0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(3))
      0: return 8'h7f;
      1: return 8'h80;
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  task automatic rand_phase(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        a = pick(); b = pick(); c = pick(); d = pick();
        round_en = 1'($urandom_range(1));
      end
      q_ready = ($urandom_range(3) != 0);
      cnt_clr = ($urandom_range(15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    q_ready = 1'b1;
  endtask

  int hs0, first_cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; round_en = 1'b0; q_ready = 1'b1; cnt_clr = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    @(posedge clk); #1;
    mon_on = 1;
    @(negedge clk);
    chk("rst_q_valid", qv0, 0);
    chk("rst_q", q0, 0);
    chk("rst_q_ovf", ov0, 0);
    chk("rst_ovf_cnt", cnt0, 0);
    chk("rst_in_ready", ir0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic: (3 * 10 - 4) >>> 1 = 13, four cycles after acceptance.
    send(5, 2, 3, 1, 0);
    wait_result();
    chk("basic_q", $signed(r_q0), 13);
    chk("basic_q16", $signed(r_q2), 13);
    chk("basic_ovf", r_ov0, 0);
    chk("basic_latency", r_cyc - acc_cyc, 4);

    // Rounding: r = -7 gives floor -4 and half-up -3, delivered back to back.
    send(2, 5, 0, 1, 0);
    send(2, 5, 0, 1, 1);
    wait_result();
    chk("round_floor", $signed(r_q0), -4);
    first_cyc = r_cyc;
    wait_result();
    chk("round_half_up", $signed(r_q0), -3);
    chk("round_back_to_back", r_cyc - first_cyc, 1);

    // Overflow: s = 48705. Saturated results are 127 (8 bit) and 32767 (16 bit).
    // The wrapped 8-bit result is 65.
    send(127, -128, 127, 0, 0);
    wait_result();
    chk("sat_q", $signed(r_q0), 127);
    chk("sat_ovf", r_ov0, 1);
    chk("wrap_q", $signed(r_q1), 65);
    chk("wrap_ovf", r_ov1, 1);
    chk("sat16_q", $signed(r_q2), 32767);
    chk("sat16_ovf", r_ov2, 1);
    chk("sat_cnt", cnt0, 1);
    chk("sat16_cnt", cnt2, 1);

    // Four more overflows: the 2-bit counters stop at 3 and the 4-bit one reaches 5.
    fork
      begin repeat (4) send(127, -128, 127, 0, 0); end
      begin repeat (4) wait_result(); end
    join
    chk("cnt_saturated", cnt0, 3);
    chk("cnt_wrap_saturated", cnt1, 3);
    chk("cnt16_five", cnt2, 5);

    // A clear in the same cycle as an overflow handshake wins.
    q_ready = 1'b0;
    send(-128, 127, 127, 0, 1);
    wait_valid();
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    q_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_priority", cnt0, 0);
    chk("clr_priority16", cnt2, 0);

    // Backpressure: six beats, with the sink stalled after the first result arrives.
    q_ready = 1'b0;
    hs0 = n_hs;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i * 9 + 1, 3 - i, i - 2, 2 * i - 5, i[0]);
      end
      begin
        wait_valid();
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", ir0, 0);
        end
        @(posedge clk); #1;
        q_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", n_hs - hs0, 6);

    // Randomized traffic.
    rand_phase(600);
    drain();

    // Reset mid-flight: two beats accepted, reset while a third is offered.
    q_ready = 1'b1;
    m_cnt0 = m_cnt0;
    send(40, -20, 5, 3, 0);
    send(-60, 70, 9, -8, 1);
    a = 8'd11; b = 8'd1; c = 8'd2; d = 8'd3; round_en = 1'b0;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_q_valid", qv0, 0);
    chk("midrst_ovf_cnt", cnt0, 0);
    chk("midrst_ovf_cnt16", cnt2, 0);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_stale", qv0, 0);
    end
    @(posedge clk); #1;
    send(10, 3, 2, -5, 1);
    wait_result();
    chk("midrst_new_q", $signed(r_q0), 35);
    chk("midrst_new_latency", r_cyc - acc_cyc, 4);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/expr_pipe_hs.md
Name: expr_pipe_hs

Overview:
- Parametrised successor to the team's fixed 4-stage arithmetic pipeline.
- Computes q = ((a - b) * (1 + 3c) - 4d) >>> 1 per transaction, at full internal precision.
- Adds valid/ready handshake with backpressure, a per-transaction rounding mode, a selectable overflow policy (wrap or saturate), an overflow flag, and a saturating overflow-event counter.
- Sits between a valid/ready operand source and a valid/ready result sink.

Parameters:
- WIDTH, 32, signed width of inputs a, b, c, d.
- OUT_WIDTH, 32, signed width of result q.
- SAT_EN, 1. 1 = saturate q on overflow; 0 = wrap (keep low OUT_WIDTH bits).
- CNT_WIDTH, 16, width of the overflow event counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  signed operand.
- b  in  WIDTH  signed operand.
- c  in  WIDTH  signed operand.
- d  in  WIDTH  signed operand.
- round_en  in  1  sampled with the beat. 0 = floor shift; 1 = round half-up.
- q_valid  out  1  result valid.
- q_ready  in  1  sink accepts the result.
- q  out  OUT_WIDTH  signed result.
- q_ovf  out  1  result overflowed OUT_WIDTH; qualified by q_valid.
- ovf_cnt  out  CNT_WIDTH  count of delivered overflowed results; saturates at all-ones.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All stage valids, q_valid, q, q_ovf and ovf_cnt go to 0.
  - in_ready is 0 during the reset cycle.
  - Reset mid-operation discards all in-flight beats; no partial results are emitted.
- Pipeline structure:
  - Four register stages, one global enable: en = !q_valid || q_ready. in_ready = en (when not in reset).
  - A beat is accepted when in_valid && in_ready. With no stall, q_valid rises 4 cycles after acceptance.
  - Throughput is 1 beat/cycle.
  - When en=0, every stage, including the valid bits, holds.
  - Bubbles are not collapsed.
- Stage operations (all signed, no intermediate truncation):
  - S1: register a, b, c, d and round_en.
  - S2: diff = a - b (WIDTH+1 bits); k = 1 + 3c (WIDTH+3 bits); d4 = 4d (WIDTH+3 bits).
  - S3: p = diff * k (2*WIDTH+4 bits); d4 is forwarded.
  - S4: r = p - d4 (2*WIDTH+5 bits). Then:
    - round_en=0: s = r >>> 1.
    - round_en=1: s = (r + 1) >>> 1.
- Output formation:
  - Overflow: s lies outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - q_ovf = overflow.
  - SAT_EN=1: q is clamped to the max/min representable value.
  - SAT_EN=0: q = s[OUT_WIDTH-1:0].
- Output hold: while q_valid && !q_ready, q, q_ovf and q_valid are stable.
- Overflow counter:
  - Increments by 1 on each handshake (q_valid && q_ready) with q_ovf=1.
  - Stops at 2^CNT_WIDTH-1.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Bubble outputs: stages not holding valid data may carry any value; q is meaningful only when q_valid=1.

Test Plan:
- Basic: WIDTH=32, a=5, b=2, c=3, d=1, round_en=0, q_ready=1 -> q=13, q_ovf=0, q_valid exactly 4 cycles after acceptance.
- Rounding: a=2, b=5, c=0, d=1 (r=-7).
  - round_en=0 -> q=-4.
  - Same operands, round_en=1 -> q=-3.
  - Both beats back-to-back, results delivered in order.
- Saturate/wrap: WIDTH=8, OUT_WIDTH=8, a=127, b=-128, c=127, d=0, round_en=0.
  - SAT_EN=1 -> q=127, q_ovf=1, ovf_cnt=1.
  - SAT_EN=0 -> q=65, q_ovf=1.
- Backpressure:
  - Stream 6 distinct beats; hold q_ready=0 for 5 cycles after the first result.
  - Required: q stable, in_ready=0 while stalled, then all 6 results in order with no loss or duplication.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle at cycle 2 -> q_valid=0, ovf_cnt=0, no old result ever appears; a new beat afterwards returns correctly after 4 cycles.
- Counter: CNT_WIDTH=2.
  - 4 overflowing results -> ovf_cnt stays at 3.
  - cnt_clr asserted in the same cycle as an overflow handshake -> ovf_cnt=0.
